// File: rtl/int_sched_nested_pkg.sv
// Shared types for the nesting interrupt scheduler: FSM states and priority-stack entry.
package int_sched_nested_pkg;

    // Stack fields are sized for the largest supported configuration and narrowed at use.
    localparam int STK_ID_W   = 8;
    localparam int STK_PRIO_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        TAKE,
        GUARD
    } int_sched_state_e;

    typedef struct packed {
        logic [STK_ID_W-1:0]   id;
        logic [STK_PRIO_W-1:0] prio;
    } stack_entry_t;

endpackage

// File: rtl/int_prio_select.sv
// Combinational winner select: highest priority among eligible sources, lowest index on ties.
module int_prio_select #(
    parameter int NUM_SRC    = 8,
    parameter int PRIO_WIDTH = 3
) (
    input  logic [NUM_SRC-1:0]            elig,
    input  logic [NUM_SRC*PRIO_WIDTH-1:0] prio,
    output logic                          valid,
    output logic [$clog2(NUM_SRC)-1:0]    win_id,
    output logic [PRIO_WIDTH-1:0]         win_prio
);

    localparam int IDW = $clog2(NUM_SRC);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        valid    = 1'b0;
        win_id   = '0;
        win_prio = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            // Strict compare keeps the earlier (lower) index on equal priority.
            if (elig[i] && (!valid || prio[i*PRIO_WIDTH +: PRIO_WIDTH] > win_prio)) begin
                valid    = 1'b1;
                win_id   = IDW'(i);
                win_prio = prio[i*PRIO_WIDTH +: PRIO_WIDTH];
            end
        end
    end

endmodule

// File: rtl/int_sched_nested.sv
// Nesting interrupt scheduler: pending latches, priority stack, take/guard FSM and
// registered jump / state-save / ack outputs.
module int_sched_nested
    import int_sched_nested_pkg::*;
#(
    parameter int NUM_SRC      = 8,
    parameter int PRIO_WIDTH   = 3,
    parameter int DEPTH        = 4,
    parameter int VEC_WIDTH    = 12,
    parameter int VEC_STRIDE   = 16,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SRC-1:0]            src_req,
    input  logic [NUM_SRC-1:0]            src_edge,
    input  logic [NUM_SRC-1:0]            src_en,
    input  logic [NUM_SRC*PRIO_WIDTH-1:0] src_prio,
    input  logic                          ee,
    input  logic                          block,
    input  logic                          rest,
    output logic                          jump,
    output logic [VEC_WIDTH-1:0]          jump_vec,
    output logic                          save_we,
    output logic [NUM_SRC-1:0]            src_ack,
    output logic [$clog2(DEPTH+1)-1:0]    depth,
    output logic [$clog2(NUM_SRC)-1:0]    active_id
);

    localparam int IDW = $clog2(NUM_SRC);
    localparam int DW  = $clog2(DEPTH + 1);
    localparam int SPW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [DW-1:0] DEPTH_FULL = DW'(DEPTH);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);

    int_sched_state_e state, state_d;
    logic [CW-1:0]       guard_cnt, guard_cnt_d;
    logic [NUM_SRC-1:0]  req_q, pending, pending_d, clr, elig;
    stack_entry_t        stack [DEPTH];
    stack_entry_t        take_entry;
    logic [STK_PRIO_W-1:0] top_prio;
    logic [SPW-1:0]      top_idx;
    logic [DW-1:0]       depth_pop;
    logic                pop, take, win_valid;
    logic [IDW-1:0]      win_id;
    logic [PRIO_WIDTH-1:0] win_prio;

    assign save_we = jump;
    assign pop     = rest && (depth != '0);

    // Eligibility: strictly more urgent than the running handler, and room to nest.
    always_comb begin
        top_idx   = SPW'(depth - 1'b1);
        top_prio  = '0;
        depth_pop = pop ? depth - 1'b1 : depth;
        if (depth != '0) top_prio = stack[top_idx].prio;
        for (int i = 0; i < NUM_SRC; i++) begin
            elig[i] = pending[i] && (depth < DEPTH_FULL) &&
                      ((depth == '0) || (STK_PRIO_W'(src_prio[i*PRIO_WIDTH +: PRIO_WIDTH]) > top_prio));
        end
    end

    int_prio_select #(
        .NUM_SRC    (NUM_SRC),
        .PRIO_WIDTH (PRIO_WIDTH)
    ) u_select (
        .elig     (elig),
        .prio     (src_prio),
        .valid    (win_valid),
        .win_id   (win_id),
        .win_prio (win_prio)
    );

    // Edge sources latch until taken (a new edge beats the clear); level sources follow the request.
    always_comb begin
        clr = '0;
        if (state == TAKE) clr[IDW'(take_entry.id)] = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) begin
            pending_d[i] = src_edge[i]
                ? (src_en[i] & ((src_req[i] & ~req_q[i]) | (pending[i] & ~clr[i])))
                : (src_req[i] & src_en[i]);
        end
    end

    always_comb begin
        state_d     = state;
        guard_cnt_d = guard_cnt;
        take        = 1'b0;
        unique case (state)
            IDLE: begin
                if (win_valid && ee && !block && !pop) begin
                    take    = 1'b1;
                    state_d = TAKE;
                end
            end
            TAKE: begin
                guard_cnt_d = '0;
                state_d     = (GUARD_CYCLES == 0) ? IDLE : GUARD;
            end
            GUARD: begin
                if (guard_cnt == GUARD_LAST) state_d = IDLE;
                else                         guard_cnt_d = guard_cnt + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            guard_cnt  <= '0;
            req_q      <= '0;
            pending    <= '0;
            depth      <= '0;
            active_id  <= '0;
            jump       <= 1'b0;
            jump_vec   <= '0;
            src_ack    <= '0;
            take_entry <= '0;
        end else begin
            state     <= state_d;
            guard_cnt <= guard_cnt_d;
            req_q     <= src_req;
            pending   <= pending_d;
            jump      <= take;
            src_ack   <= take ? (NUM_SRC'(1) << win_id) : '0;
            jump_vec  <= take ? VEC_WIDTH'(int'(win_id) * VEC_STRIDE) : '0;
            if (take) take_entry <= '{id: STK_ID_W'(win_id), prio: STK_PRIO_W'(win_prio)};
            // A pop in the TAKE cycle removes the old top before the new entry lands.
            if (state == TAKE) begin
                depth     <= depth_pop + 1'b1;
                active_id <= IDW'(take_entry.id);
            end else if (pop) begin
                depth     <= depth_pop;
                active_id <= (depth_pop != '0) ? IDW'(stack[SPW'(depth_pop - 1'b1)].id) : '0;
            end
        end
    end

    // NOTE: stack storage has no reset; entries above depth are never read, so clearing depth discards them.
    always_ff @(posedge clk) begin
        if (state == TAKE) stack[SPW'(depth_pop)] <= take_entry;
    end

endmodule

// File: tb/tb_int_sched_nested.sv
// Directed bench for int_sched_nested: per-cycle vector table plus hand-written nesting sequences.
module tb_int_sched_nested;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  src_req, src_edge, src_en;
    logic [23:0] src_prio;
    logic        ee, block, rest;
    logic        jump, save_we;
    logic [11:0] jump_vec;
    logic [7:0]  src_ack;
    logic [2:0]  depth, active_id;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    int_sched_nested #(
        .NUM_SRC(8), .PRIO_WIDTH(3), .DEPTH(4),
        .VEC_WIDTH(12), .VEC_STRIDE(16), .GUARD_CYCLES(2)
    ) dut (
        .clk(clk), .reset(reset),
        .src_req(src_req), .src_edge(src_edge), .src_en(src_en), .src_prio(src_prio),
        .ee(ee), .block(block), .rest(rest),
        .jump(jump), .jump_vec(jump_vec), .save_we(save_we), .src_ack(src_ack),
        .depth(depth), .active_id(active_id)
    );

    typedef struct {
        logic        rst;
        logic [23:0] prio;
        logic [7:0]  req;
        logic        rest;
        logic        jump;
        logic [11:0] vec;
        logic [7:0]  ack;
        logic [2:0]  depth;
        logic [2:0]  aid;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_jump(input int budget, input string name);
        int n = 0;
        while (jump !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check({name, ".seen"}, 32'(jump), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1; src_req = '0; rest = 1'b0; ee = 1'b1; block = 1'b0;
        src_edge = 8'hFF; src_en = 8'hFF;
        tick();
        check("reset.depth", 32'(depth), 32'd0);
        reset = 1'b0;
    endtask

    function automatic logic [23:0] pr3(input int ia, input int pa, input int ib, input int pb,
                                        input int ic, input int pc);
        logic [23:0] r = '0;
        r[ia*3 +: 3] = 3'(pa);
        r[ib*3 +: 3] = 3'(pb);
        r[ic*3 +: 3] = 3'(pc);
        return r;
    endfunction

    function automatic vec_t mk(input logic rst, input logic [23:0] prio, input logic [7:0] req,
                                input logic rs, input logic j, input logic [11:0] v,
                                input logic [7:0] a, input logic [2:0] d, input logic [2:0] id);
        vec_t t;
        t.rst = rst; t.prio = prio; t.req = req; t.rest = rs;
        t.jump = j; t.vec = v; t.ack = a; t.depth = d; t.aid = id;
        return t;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] p1, p2, p3, pf;
        p1 = pr3(3, 2, 3, 2, 3, 2);
        p2 = pr3(1, 4, 5, 4, 5, 4);
        p3 = pr3(2, 1, 6, 5, 0, 1);

        reset = 1'b1; src_req = '0; src_edge = 8'hFF; src_en = 8'hFF;
        src_prio = '0; ee = 1'b1; block = 1'b0; rest = 1'b0;

        tbl.push_back(mk(1, p1, 8'h00, 0, 0, 12'd0,  8'h00, 0, 0));
        // single edge source 3
        tbl.push_back(mk(0, p1, 8'h08, 0, 0, 12'd0,  8'h00, 0, 0));
        tbl.push_back(mk(0, p1, 8'h08, 0, 1, 12'd48, 8'h08, 0, 0));
        tbl.push_back(mk(0, p1, 8'h00, 0, 0, 12'd0,  8'h00, 1, 3));
        tbl.push_back(mk(0, p1, 8'h00, 0, 0, 12'd0,  8'h00, 1, 3));
        tbl.push_back(mk(0, p1, 8'h00, 0, 0, 12'd0,  8'h00, 1, 3));
        tbl.push_back(mk(0, p1, 8'h00, 1, 0, 12'd0,  8'h00, 0, 0));
        // tie between 1 and 5 at prio 4
        tbl.push_back(mk(0, p2, 8'h22, 0, 0, 12'd0,  8'h00, 0, 0));
        tbl.push_back(mk(0, p2, 8'h22, 0, 1, 12'd16, 8'h02, 0, 0));
        tbl.push_back(mk(0, p2, 8'h00, 0, 0, 12'd0,  8'h00, 1, 1));
        tbl.push_back(mk(0, p2, 8'h00, 0, 0, 12'd0,  8'h00, 1, 1));
        tbl.push_back(mk(0, p2, 8'h00, 0, 0, 12'd0,  8'h00, 1, 1));
        tbl.push_back(mk(0, p2, 8'h00, 1, 0, 12'd0,  8'h00, 0, 0));
        tbl.push_back(mk(0, p2, 8'h00, 0, 1, 12'd80, 8'h20, 0, 0));
        tbl.push_back(mk(0, p2, 8'h00, 0, 0, 12'd0,  8'h00, 1, 5));
        tbl.push_back(mk(0, p2, 8'h00, 0, 0, 12'd0,  8'h00, 1, 5));
        tbl.push_back(mk(0, p2, 8'h00, 0, 0, 12'd0,  8'h00, 1, 5));
        tbl.push_back(mk(0, p2, 8'h00, 1, 0, 12'd0,  8'h00, 0, 0));
        // preemption 2 -> 6 at minimum spacing, then equal-priority source 0 waits
        tbl.push_back(mk(0, p3, 8'h04, 0, 0, 12'd0,  8'h00, 0, 0));
        tbl.push_back(mk(0, p3, 8'h04, 0, 1, 12'd32, 8'h04, 0, 0));
        tbl.push_back(mk(0, p3, 8'h44, 0, 0, 12'd0,  8'h00, 1, 2));
        tbl.push_back(mk(0, p3, 8'h44, 0, 0, 12'd0,  8'h00, 1, 2));
        tbl.push_back(mk(0, p3, 8'h44, 0, 0, 12'd0,  8'h00, 1, 2));
        tbl.push_back(mk(0, p3, 8'h44, 0, 1, 12'd96, 8'h40, 1, 2));
        tbl.push_back(mk(0, p3, 8'h00, 0, 0, 12'd0,  8'h00, 2, 6));
        tbl.push_back(mk(0, p3, 8'h00, 0, 0, 12'd0,  8'h00, 2, 6));
        tbl.push_back(mk(0, p3, 8'h00, 0, 0, 12'd0,  8'h00, 2, 6));
        tbl.push_back(mk(0, p3, 8'h00, 1, 0, 12'd0,  8'h00, 1, 2));
        tbl.push_back(mk(0, p3, 8'h01, 0, 0, 12'd0,  8'h00, 1, 2));
        tbl.push_back(mk(0, p3, 8'h01, 0, 0, 12'd0,  8'h00, 1, 2));
        tbl.push_back(mk(0, p3, 8'h01, 0, 0, 12'd0,  8'h00, 1, 2));
        tbl.push_back(mk(0, p3, 8'h01, 1, 0, 12'd0,  8'h00, 0, 0));
        tbl.push_back(mk(0, p3, 8'h01, 0, 1, 12'd0,  8'h01, 0, 0));
        tbl.push_back(mk(0, p3, 8'h00, 0, 0, 12'd0,  8'h00, 1, 0));
        tbl.push_back(mk(0, p3, 8'h00, 0, 0, 12'd0,  8'h00, 1, 0));
        tbl.push_back(mk(0, p3, 8'h00, 0, 0, 12'd0,  8'h00, 1, 0));
        tbl.push_back(mk(0, p3, 8'h00, 1, 0, 12'd0,  8'h00, 0, 0));

        foreach (tbl[i]) begin
            reset = tbl[i].rst; src_prio = tbl[i].prio; src_req = tbl[i].req; rest = tbl[i].rest;
            tick();
            check($sformatf("row%0d.jump", i),    32'(jump),      32'(tbl[i].jump));
            check($sformatf("row%0d.save_we", i), 32'(save_we),   32'(tbl[i].jump));
            check($sformatf("row%0d.vec", i),     32'(jump_vec),  32'(tbl[i].vec));
            check($sformatf("row%0d.ack", i),     32'(src_ack),   32'(tbl[i].ack));
            check($sformatf("row%0d.depth", i),   32'(depth),     32'(tbl[i].depth));
            check($sformatf("row%0d.aid", i),     32'(active_id), 32'(tbl[i].aid));
        end

        // ee / block hold off a pending edge source; rest suppresses a same-cycle take
        do_reset();
        src_prio = pr3(4, 3, 6, 5, 6, 5);
        ee = 1'b0; src_req = 8'h10; tick(); src_req = 8'h00;
        for (int k = 0; k < 3; k++) begin tick(); check("ee0.nojump", 32'(jump), 32'd0); end
        ee = 1'b1; block = 1'b1;
        for (int k = 0; k < 2; k++) begin tick(); check("block.nojump", 32'(jump), 32'd0); end
        block = 1'b0; tick();
        check("release.jump", 32'(jump), 32'd1);
        check("release.vec", 32'(jump_vec), 32'd64);
        check("release.ack", 32'(src_ack), 32'h10);
        tick();
        check("release.depth", 32'(depth), 32'd1);
        check("release.aid", 32'(active_id), 32'd4);
        tick(); tick();
        ee = 1'b0; src_req = 8'h40; tick(); src_req = 8'h00;
        ee = 1'b1; rest = 1'b1; tick(); rest = 1'b0;
        check("rest_sup.jump", 32'(jump), 32'd0);
        check("rest_sup.depth", 32'(depth), 32'd0);
        tick();
        check("after_rest.jump", 32'(jump), 32'd1);
        check("after_rest.vec", 32'(jump_vec), 32'd96);
        tick();
        check("after_rest.aid", 32'(active_id), 32'd6);

        // level source latency
        do_reset();
        src_edge = 8'hDF; src_prio = pr3(5, 2, 5, 2, 5, 2);
        src_req = 8'h20; tick();
        check("level.early", 32'(jump), 32'd0);
        tick();
        check("level.jump", 32'(jump), 32'd1);
        check("level.ack", 32'(src_ack), 32'h20);
        src_req = 8'h00; tick();
        check("level.aid", 32'(active_id), 32'd5);
        src_edge = 8'hFF;

        // fill all four stack levels, then a prio-7 request waits for a free slot
        do_reset();
        pf = '0;
        pf[0 +: 3] = 3'd1; pf[3 +: 3] = 3'd2; pf[6 +: 3] = 3'd3; pf[9 +: 3] = 3'd4; pf[21 +: 3] = 3'd7;
        src_prio = pf;
        for (int k = 0; k < 4; k++) begin
            src_req = 8'(1 << k); tick(); src_req = 8'h00;
            wait_jump(8, $sformatf("fill%0d", k));
            check($sformatf("fill%0d.vec", k), 32'(jump_vec), 32'(k * 16));
            tick();
            check($sformatf("fill%0d.depth", k), 32'(depth), 32'(k + 1));
            check($sformatf("fill%0d.aid", k), 32'(active_id), 32'(k));
            tick(); tick();
        end
        src_req = 8'h80; tick(); src_req = 8'h00;
        for (int k = 0; k < 6; k++) begin tick(); check("full.nojump", 32'(jump), 32'd0); end
        check("full.depth", 32'(depth), 32'd4);
        rest = 1'b1; tick(); rest = 1'b0;
        check("full.pop_depth", 32'(depth), 32'd3);
        check("full.pop_aid", 32'(active_id), 32'd2);
        check("full.pop_nojump", 32'(jump), 32'd0);
        tick();
        check("full.take7", 32'(jump), 32'd1);
        check("full.vec7", 32'(jump_vec), 32'd112);
        tick();
        check("full.depth7", 32'(depth), 32'd4);
        check("full.aid7", 32'(active_id), 32'd7);
        tick(); tick();
        for (int k = 0; k < 4; k++) begin
            rest = 1'b1; tick();
            check($sformatf("unwind%0d.depth", k), 32'(depth), 32'(3 - k));
            check($sformatf("unwind%0d.aid", k), 32'(active_id), (k < 3) ? 32'(2 - k) : 32'd0);
        end
        tick();
        check("empty_rest.depth", 32'(depth), 32'd0);
        rest = 1'b0;

        // reset during GUARD with two levels nested and a pending source
        do_reset();
        src_prio = pr3(2, 1, 6, 5, 3, 6);
        src_req = 8'h04; tick(); src_req = 8'h00;
        wait_jump(8, "rg_first");
        check("rg_first.vec", 32'(jump_vec), 32'd32);
        tick();
        src_req = 8'h40; tick(); src_req = 8'h00;
        wait_jump(8, "rg_second");
        check("rg_second.vec", 32'(jump_vec), 32'd96);
        tick();
        check("rg.depth2", 32'(depth), 32'd2);
        src_req = 8'h08; tick();
        reset = 1'b1; src_req = 8'h00; tick();
        check("rg.jump", 32'(jump), 32'd0);
        check("rg.save_we", 32'(save_we), 32'd0);
        check("rg.vec", 32'(jump_vec), 32'd0);
        check("rg.ack", 32'(src_ack), 32'd0);
        check("rg.depth", 32'(depth), 32'd0);
        check("rg.aid", 32'(active_id), 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin tick(); check("rg.pending_cleared", 32'(jump), 32'd0); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
